parity_tx: RTL and testbench
============================

Name: parity_tx

Overview:
- Serial parity transmitter. Accepts a parallel word through a valid/ready handshake and shifts it out LSB-first on a single-bit line, followed by one parity bit.
- Counterpart of the team's serial parity detector. In even-parity mode, the full frame (data bits plus parity bit) carries an even number of ones, so a detector that starts at EVEN and is fed the frame ends back at EVEN with output 0.
- Sits at the sending end of the serial parity link.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 2..32.
- ODD_PARITY, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (parity bit = inverted XOR).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on accept.
- load  input  1  request to send data_in.
- ready  output  1  block can accept a word this cycle.
- z  output  1  serial data/parity bit, registered.
- z_valid  output  1  z carries a frame bit this cycle.
- z_first  output  1  z carries data bit 0 of a frame.
- z_par  output  1  z carries the parity bit.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, z=0, z_valid=0, z_first=0, z_par=0, shift register=0, bit counter=0, parity accumulator=0. ready=1 once rst_n is high.
- States: IDLE, DATA, PAR. Frame register width is WIDTH; bit counter width is clog2(WIDTH).
- ready is combinational from state only: ready=1 in IDLE or PAR, 0 in DATA.
- Accept occurs on a rising edge where load=1 and ready=1. At that edge:
  - data_in is captured.
  - z <= data_in[0], z_valid <= 1, z_first <= 1, z_par <= 0.
  - Counter <= 1. Parity accumulator <= data_in[0].
  - State <= DATA.
- DATA state, each edge:
  - z <= captured bit[counter]; z_first <= 0.
  - Accumulator ^= that bit; counter increments.
  - On the edge that outputs bit WIDTH-1, state stays DATA.
  - On the following edge, state <= PAR, z <= accumulator ^ ODD_PARITY, z_par <= 1.
- Timing for an accept at edge k:
  - Data bits appear after edges k .. k+WIDTH-1.
  - Parity bit appears after edge k+WIDTH.
  - z_valid is high for exactly WIDTH+1 cycles.
  - Latency from accept to first bit on z is one edge (the accept edge itself).
- PAR state, next edge:
  - If load=1: back-to-back accept with no idle gap; z <= new data_in[0], z_first <= 1, z_par <= 0.
  - Otherwise: state <= IDLE, z <= 0, z_valid <= 0, z_par <= 0.
- load while ready=0 (DATA state) is ignored, with no queuing. Changes to data_in after accept have no effect on the frame in flight.
- IDLE with load=0: all outputs hold reset values.
- Reset asserted mid-frame aborts the frame immediately. No partial parity bit is emitted. After release, the block is in IDLE with ready=1.
- z_first and z_par are never high in the same cycle. Both are 0 whenever z_valid=0.

Test Plan:
- Reset then load data_in=8'hA5 for one cycle -> z over 9 cycles = 1,0,1,0,0,1,0,1 then parity 0; z_first high in cycle 1 only; z_par high in cycle 9 only; ready low for cycles 1-8, high in cycle 9; then IDLE with z=0, z_valid=0.
- data_in=8'h07, even mode -> bits 1,1,1,0,0,0,0,0, parity 1. Feeding the 9 bits to the parity detector gives a final z=0.
- ODD_PARITY=1, data_in=8'hA5 -> parity bit 1; data_in=8'hFF -> parity bit 1; data_in=8'h00 -> parity bit 1.
- Back-to-back: 8'h01 accepted, load held high with 8'h80 presented during the parity cycle -> 18 consecutive z_valid cycles: 1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,1,1; z_first pulses at cycles 1 and 10.
- load pulsed with 8'hFF during bit 3 of an 8'h3C frame -> ignored; the frame completes as 0,0,1,1,1,1,0,0 with parity 0; block then returns to IDLE.
- rst_n driven low mid-edge-cycle during bit 5 of 8'hA5 -> z, z_valid, z_first, z_par go to 0 immediately without waiting for clk; after release, ready=1 and a new accept of 8'h0F yields 1,1,1,1,0,0,0,0, parity 0.

Source files
------------

// File: rtl/parity_tx.sv
// Serial parity transmitter: accepts a parallel word on load/ready, shifts it out LSB-first on z,
// then appends one parity bit. Back-to-back frames are accepted during the parity cycle.
module parity_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             z,
  output logic             z_valid,
  output logic             z_first,
  output logic             z_par
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  frame_q, frame_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              acc_q, acc_d;
  // Set once bit WIDTH-1 is on z, so the next edge emits parity even when the counter wraps.
  logic              last_q, last_d;
  logic              z_q, z_d;
  logic              z_valid_q, z_valid_d;
  logic              z_first_q, z_first_d;
  logic              z_par_q, z_par_d;
  logic              cur_bit;

  assign cur_bit = frame_q[cnt_q];

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last_d    = last_q;
    z_d       = z_q;
    z_valid_d = z_valid_q;
    z_first_d = z_first_q;
    z_par_d   = z_par_q;
    ready     = (state_q != StData);

    unique case (state_q)
      StIdle, StPar: begin
        if (load) begin
          state_d   = StData;
          frame_d   = data_in;
          cnt_d     = CntW'(1);
          acc_d     = data_in[0];
          last_d    = (WIDTH == 1);
          z_d       = data_in[0];
          z_valid_d = 1'b1;
          z_first_d = 1'b1;
          z_par_d   = 1'b0;
        end else begin
          state_d   = StIdle;
          z_d       = 1'b0;
          z_valid_d = 1'b0;
          z_first_d = 1'b0;
          z_par_d   = 1'b0;
        end
      end
      StData: begin
        z_first_d = 1'b0;
        if (last_q) begin
          state_d = StPar;
          z_d     = acc_q ^ ODD_PARITY;
          z_par_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          z_d    = cur_bit;
          acc_d  = acc_q ^ cur_bit;
          cnt_d  = cnt_q + CntW'(1);
          last_d = (cnt_q == CntLast);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      last_q    <= 1'b0;
      z_q       <= 1'b0;
      z_valid_q <= 1'b0;
      z_first_q <= 1'b0;
      z_par_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      z_first_q <= z_first_d;
      z_par_q   <= z_par_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign z_first = z_first_q;
  assign z_par   = z_par_q;

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: one even-parity and one odd-parity instance on a shared clock.
module tb_parity_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data0, data1;
  logic       load0, load1;
  logic       ready0, z0, zv0, zf0, zp0;
  logic       ready1, z1, zv1, zf1, zp1;

  int n_cmp = 0;
  int n_err = 0;

  parity_tx #(.WIDTH(8), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .data_in(data0), .load(load0), .ready(ready0),
    .z(z0), .z_valid(zv0), .z_first(zf0), .z_par(zp0)
  );

  parity_tx #(.WIDTH(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .load(load1), .ready(ready1),
    .z(z1), .z_valid(zv1), .z_first(zf1), .z_par(zp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit odd, input logic [7:0] d);
    if (odd) begin load1 = 1'b1; data1 = d; end
    else begin load0 = 1'b1; data0 = d; end
    tick();
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  // exp[i] is the z value required in frame cycle i+1; exp[8] is the parity bit.
  task automatic stream(input string name, input bit odd, input logic [8:0] exp,
                        input bit poke, input bit chain, input logic [7:0] nd);
    logic fx;
    fx = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load0 = 1'b0;
      load1 = 1'b0;
      chk($sformatf("%s z[%0d]", name, i), odd ? z1 : z0, exp[i]);
      chk($sformatf("%s zv[%0d]", name, i), odd ? zv1 : zv0, 1'b1);
      chk($sformatf("%s zf[%0d]", name, i), odd ? zf1 : zf0, i == 0);
      chk($sformatf("%s zp[%0d]", name, i), odd ? zp1 : zp0, i == 8);
      chk($sformatf("%s rdy[%0d]", name, i), odd ? ready1 : ready0, i == 8);
      fx = fx ^ (odd ? z1 : z0);
      if (poke && i == 3) begin load0 = 1'b1; data0 = 8'hFF; end
      if (chain && i == 8) begin
        if (odd) begin load1 = 1'b1; data1 = nd; end
        else begin load0 = 1'b1; data0 = nd; end
      end
      tick();
    end
    load0 = 1'b0;
    load1 = 1'b0;
    // A detector starting at EVEN ends at EVEN for even frames, ODD for odd frames.
    chk({name, " frame_xor"}, fx, odd);
    if (!chain) begin
      chk({name, " idle z"}, odd ? z1 : z0, 1'b0);
      chk({name, " idle zv"}, odd ? zv1 : zv0, 1'b0);
      chk({name, " idle rdy"}, odd ? ready1 : ready0, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
    data0 = '0;
    data1 = '0;
    #12;
    chk("rst z", z0, 1'b0);
    chk("rst zv", zv0, 1'b0);
    chk("rst zf", zf0, 1'b0);
    chk("rst zp", zp0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst rdy", ready0, 1'b1);
    tick();
    chk("idle hold zv", zv0, 1'b0);

    accept(1'b0, 8'hA5);
    stream("a5", 1'b0, 9'b0_1010_0101, 1'b0, 1'b0, 8'h00);

    accept(1'b0, 8'h07);
    stream("07", 1'b0, 9'b1_0000_0111, 1'b0, 1'b0, 8'h00);

    accept(1'b1, 8'hA5);
    stream("odd_a5", 1'b1, 9'b1_1010_0101, 1'b0, 1'b0, 8'h00);
    accept(1'b1, 8'hFF);
    stream("odd_ff", 1'b1, 9'b1_1111_1111, 1'b0, 1'b0, 8'h00);
    accept(1'b1, 8'h00);
    stream("odd_00", 1'b1, 9'b1_0000_0000, 1'b0, 1'b0, 8'h00);

    accept(1'b0, 8'h01);
    stream("b2b_01", 1'b0, 9'b1_0000_0001, 1'b0, 1'b1, 8'h80);
    stream("b2b_80", 1'b0, 9'b1_1000_0000, 1'b0, 1'b0, 8'h00);

    accept(1'b0, 8'h3C);
    stream("ign_3c", 1'b0, 9'b0_0011_1100, 1'b1, 1'b0, 8'h00);

    // Abort mid-frame: z shows bit 5 of A5 (a 1) before reset lands between edges.
    accept(1'b0, 8'hA5);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_abort z", z0, 1'b1);
    chk("pre_abort zv", zv0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort z", z0, 1'b0);
    chk("abort zv", zv0, 1'b0);
    chk("abort zf", zf0, 1'b0);
    chk("abort zp", zp0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_abort rdy", ready0, 1'b1);
    chk("post_abort zv", zv0, 1'b0);
    accept(1'b0, 8'h0F);
    stream("0f", 1'b0, 9'b0_0000_1111, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
